mw_stage: RTL
=============

# mw_stage

Parametrised memory-writeback pipeline stage: the successor to the fixed MEM/WB register. Adds valid/ready flow control with a two-entry skid buffer, synchronous flush, bubble-safe control outputs and a built-in writeback-data select. Sits between the data-memory stage and the register-file write port; it can also be instantiated as a generic elastic stage by setting widths.

## Interface
Parameters:
- N, 32, datapath width (ALU result, read data, writeback data)
- M, 4, register-index width
Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of both entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered, never depends combinationally on out_ready
- pcload_M, regw_M, regmem_M  in  1 each  control flags from memory stage
- regScr_M  in  M  destination register index
- ALUrslt_M, readdata_M  in  N each  ALU result, memory read data
- out_valid  out  1  head entry valid
- out_ready  in  1  writeback consumes head this cycle
- pcload_W, regw_W, regmem_W  out  1 each  head control flags, forced 0 when out_valid=0
- regScr_W  out  M  head destination index
- ALUrslt_W, readdata_W  out  N each  head data
- wbdata_W  out  N  regmem_W ? readdata_W : ALUrslt_W (uses ungated regmem of head)

## Operation
- Two slots: main (head, drives outputs) and skid. State = {main_v, skid_v}; legal: EMPTY {0,0}, ONE {1,0}, FULL {1,1}. {0,1} never occurs.
- in_ready = !skid_v (registered state). Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- EMPTY: accept -> load main, ONE.
- ONE: pop & accept -> load main, stay ONE. pop only -> EMPTY. accept only -> load skid, FULL. neither -> hold.
- FULL: pop -> main <= skid, skid_v <= 0, ONE (input not accepted since in_ready=0). no pop -> hold.
- flush=1: main_v, skid_v <= 0 next edge; same-cycle accept is dropped; flush has priority over all transitions. Data registers need not clear.
- Control gating: pcload_W/regw_W/regmem_W = stored flag & main_v, so an empty or flushed stage never writes the register file or loads PC.
- Data slots update only when loaded (enable-style); no toggling on idle cycles.

## Timing
- Reset (rst=0, async): main_v=skid_v=0, all stored fields 0; hence out_valid=0, in_ready=1, all *_W outputs and wbdata_W = 0. Release on rst rising, synchronised externally.
- Latency: input accepted at edge k appears at outputs after edge k (1 cycle) when stage was EMPTY or ONE-with-pop.
- Throughput: 1 entry/cycle sustained with out_ready=1.
- Backpressure: one cycle after out_ready drops with main full, a further accept fills skid; in_ready falls the cycle after that. Zero entries lost, order preserved.
- in_ready returns 1 the cycle after a pop from FULL.
- Reset mid-operation: both entries discarded immediately, no partial write visible.

## Structure
- Package mw_pkg: state enum (MW_EMPTY, MW_ONE, MW_FULL), default N/M localparams.
- Sub-module mw_slot #(N,M): one enable-loaded, async-active-low-reset slot holding {pcload, regw, regmem, regScr, ALUrslt, readdata}; instantiated twice (main, skid). Control FSM and output gating/mux live in mw_stage.

## Test plan
- Reset: drive in_valid=1 with data during rst=0 -> out_valid=0, all outputs 0, in_ready=1; after release first accepted entry appears next cycle.
- Streaming: out_ready=1, 8 entries ALUrslt=0x10..0x17, regmem=0 -> wbdata_W sequence 0x10..0x17 one per cycle, in_ready stays 1.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 (A,B,C) -> A at head, B in skid, in_ready=0, C held upstream; out_ready=1 -> outputs A, B, C in order, no loss or duplication.
- Writeback select: regmem_M=1, readdata=0xDEADBEEF, ALUrslt=0x4 -> wbdata_W=0xDEADBEEF; regmem_M=0 -> 0x4.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, regw_W=pcload_W=0, in_ready=1, flushed and same-cycle inputs never appear.
- Async reset asserted mid-FULL between edges -> outputs clear immediately, before next clk edge.

Source files
------------

// File: rtl/mw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mw_pkg : shared types and defaults for the memory-writeback stage    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mw_pkg;

   localparam int c_n_default = 32;
   localparam int c_m_default = 4;

   // Bit 1 = main slot valid, bit 0 = skid slot valid.
   typedef enum logic [1:0] {
      MW_EMPTY = 2'b00,
      MW_ONE   = 2'b10,
      MW_FULL  = 2'b11
   } mw_state_e;

endpackage : mw_pkg
`default_nettype wire

// File: rtl/mw_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mw_slot : one enable-loaded storage slot of the writeback stage      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mw_slot
   import mw_pkg::*;
#(
   parameter int N = c_n_default,
   parameter int M = c_m_default
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         pcload_d,
   input  logic         regw_d,
   input  logic         regmem_d,
   input  logic [M-1:0] regscr_d,
   input  logic [N-1:0] aluRslt_d,
   input  logic [N-1:0] readdata_d,
   output logic         pcload_q,
   output logic         regw_q,
   output logic         regmem_q,
   output logic [M-1:0] regscr_q,
   output logic [N-1:0] aluRslt_q,
   output logic [N-1:0] readdata_q
);

   logic         r_pcload;
   logic         r_regw;
   logic         r_regmem;
   logic [M-1:0] r_regscr;
   logic [N-1:0] r_alurslt;
   logic [N-1:0] r_readdata;

   // Fields only change when loaded, so idle cycles cause no toggling.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pcload   <= 1'b0;
         r_regw     <= 1'b0;
         r_regmem   <= 1'b0;
         r_regscr   <= '0;
         r_alurslt  <= '0;
         r_readdata <= '0;
      end else if (load) begin
         r_pcload   <= pcload_d;
         r_regw     <= regw_d;
         r_regmem   <= regmem_d;
         r_regscr   <= regscr_d;
         r_alurslt  <= aluRslt_d;
         r_readdata <= readdata_d;
      end
   end

   assign pcload_q   = r_pcload;
   assign regw_q     = r_regw;
   assign regmem_q   = r_regmem;
   assign regscr_q   = r_regscr;
   assign aluRslt_q  = r_alurslt;
   assign readdata_q = r_readdata;

endmodule : mw_slot
`default_nettype wire

// File: rtl/mw_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mw_stage : elastic MEM/WB stage with two-entry skid buffer, flush,   |
// |            gated control outputs and writeback-data select           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mw_stage
   import mw_pkg::*;
#(
   parameter int N = c_n_default,
   parameter int M = c_m_default
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         pcload_M,
   input  logic         regw_M,
   input  logic         regmem_M,
   input  logic [M-1:0] regScr_M,
   input  logic [N-1:0] ALUrslt_M,
   input  logic [N-1:0] readdata_M,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         pcload_W,
   output logic         regw_W,
   output logic         regmem_W,
   output logic [M-1:0] regScr_W,
   output logic [N-1:0] ALUrslt_W,
   output logic [N-1:0] readdata_W,
   output logic [N-1:0] wbdata_W
);

   mw_state_e r_state;
   logic      r_out_valid;
   logic      r_in_ready;

   logic      w_accept;
   logic      w_pop;
   logic      w_main_load;
   logic      w_skid_load;
   logic      w_main_from_skid;

   logic         w_skid_pcload;
   logic         w_skid_regw;
   logic         w_skid_regmem;
   logic [M-1:0] w_skid_regscr;
   logic [N-1:0] w_skid_alurslt;
   logic [N-1:0] w_skid_readdata;

   logic         w_main_pcload_d;
   logic         w_main_regw_d;
   logic         w_main_regmem_d;
   logic [M-1:0] w_main_regscr_d;
   logic [N-1:0] w_main_alurslt_d;
   logic [N-1:0] w_main_readdata_d;

   logic         w_main_pcload;
   logic         w_main_regw;
   logic         w_main_regmem;

   assign w_accept = in_valid & r_in_ready;
   assign w_pop    = r_out_valid & out_ready;

   // A FULL pop refills the head from skid; every other head load takes the input.
   assign w_main_from_skid = (r_state == MW_FULL);
   assign w_main_load = !flush &&
                        (((r_state == MW_EMPTY) && w_accept) ||
                         ((r_state == MW_ONE)   && w_accept && w_pop) ||
                         ((r_state == MW_FULL)  && w_pop));
   assign w_skid_load = !flush && (r_state == MW_ONE) && w_accept && !w_pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= MW_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else if (flush) begin
         r_state     <= MW_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            MW_EMPTY: begin
               if (w_accept) begin
                  r_state     <= MW_ONE;
                  r_out_valid <= 1'b1;
                  r_in_ready  <= 1'b1;
               end
            end
            MW_ONE: begin
               if (w_accept && !w_pop) begin
                  r_state     <= MW_FULL;
                  r_out_valid <= 1'b1;
                  r_in_ready  <= 1'b0;
               end else if (!w_accept && w_pop) begin
                  r_state     <= MW_EMPTY;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            MW_FULL: begin
               if (w_pop) begin
                  r_state     <= MW_ONE;
                  r_out_valid <= 1'b1;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= MW_EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      w_main_pcload_d   = pcload_M;
      w_main_regw_d     = regw_M;
      w_main_regmem_d   = regmem_M;
      w_main_regscr_d   = regScr_M;
      w_main_alurslt_d  = ALUrslt_M;
      w_main_readdata_d = readdata_M;
      if (w_main_from_skid) begin
         w_main_pcload_d   = w_skid_pcload;
         w_main_regw_d     = w_skid_regw;
         w_main_regmem_d   = w_skid_regmem;
         w_main_regscr_d   = w_skid_regscr;
         w_main_alurslt_d  = w_skid_alurslt;
         w_main_readdata_d = w_skid_readdata;
      end
   end

   mw_slot #(.N(N), .M(M)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .load       (w_skid_load),
      .pcload_d   (pcload_M),
      .regw_d     (regw_M),
      .regmem_d   (regmem_M),
      .regscr_d   (regScr_M),
      .aluRslt_d  (ALUrslt_M),
      .readdata_d (readdata_M),
      .pcload_q   (w_skid_pcload),
      .regw_q     (w_skid_regw),
      .regmem_q   (w_skid_regmem),
      .regscr_q   (w_skid_regscr),
      .aluRslt_q  (w_skid_alurslt),
      .readdata_q (w_skid_readdata)
   );

   mw_slot #(.N(N), .M(M)) u_main (
      .clk        (clk),
      .rst        (rst),
      .load       (w_main_load),
      .pcload_d   (w_main_pcload_d),
      .regw_d     (w_main_regw_d),
      .regmem_d   (w_main_regmem_d),
      .regscr_d   (w_main_regscr_d),
      .aluRslt_d  (w_main_alurslt_d),
      .readdata_d (w_main_readdata_d),
      .pcload_q   (w_main_pcload),
      .regw_q     (w_main_regw),
      .regmem_q   (w_main_regmem),
      .regscr_q   (regScr_W),
      .aluRslt_q  (ALUrslt_W),
      .readdata_q (readdata_W)
   );

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;

   // Side-effecting controls are masked so an empty head can never write back.
   assign pcload_W = w_main_pcload & r_out_valid;
   assign regw_W   = w_main_regw   & r_out_valid;
   assign regmem_W = w_main_regmem & r_out_valid;

   assign wbdata_W = w_main_regmem ? readdata_W : ALUrslt_W;

endmodule : mw_stage
`default_nettype wire
